memory_reader: RTL and testbench

Frame reader for the video pipeline. On a `frame_ready` pulse it issues one INCR read burst for the whole frame at the supplied base address. It accepts read beats into a small FIFO and replays them as an AXI-Stream master. The stream carries `tuser` on the first pixel of the frame and `tlast` on the last pixel of each line. It sits after the frame-buffer writer / AXI memory model and feeds downstream processing or display.

---
 rtl/memory_reader_pkg.sv | 23 ++
 rtl/memory_reader_sync_fifo.sv | 72 +++++++
 rtl/memory_reader.sv | 180 ++++++++++++++++++
 tb/tb_memory_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_reader_pkg.sv
// Shared types and constants for the frame reader and its read-data buffer.
package memory_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DONE
  } reader_state_t;

  localparam int unsigned DIM_W      = 16;
  localparam int unsigned LEN_W      = 32;
  localparam int unsigned UNDERRUN_W = 16;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  // Index of the last column/line for a given dimension.
  function automatic logic [DIM_W-1:0] dim_last(input logic [DIM_W-1:0] dim);
    return DIM_W'(dim - DIM_W'(1));
  endfunction

endpackage

// File: rtl/memory_reader_sync_fifo.sv
// Synchronous FIFO with a registered head word and combinational status flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = head_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Head register always mirrors the oldest entry so the output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= AW'(wr_ptr + AW'(1));
      end
      if (do_pop) begin
        rd_ptr <= AW'(rd_ptr + AW'(1));
      end
      if (do_push && !do_pop) begin
        count_q <= CW'(count_q + CW'(1));
      end else if (do_pop && !do_push) begin
        count_q <= CW'(count_q - CW'(1));
      end
      if (do_pop) begin
        if (count_q > CW'(1)) begin
          head_q <= mem[AW'(rd_ptr + AW'(1))];
        end else if (do_push) begin
          head_q <= push_data;
        end
      end else if (do_push && empty) begin
        head_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Frame reader: one INCR burst per frame, replayed as an AXI-Stream of pixels.
// Optional MEMORY_READER_UNDERRUN_CNT_EN adds a saturating sink-starvation counter.
module memory_reader
  import memory_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pixels_per_frame,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic                  busy
`ifdef MEMORY_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  reader_state_t    state;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] line;
  logic [LEN_W-1:0] beats_received;

  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             push;
  logic             pop;
  logic             accept;
  logic             dims_ok;
  logic             col_last;
  logic             line_last;

  assign read_size  = SIZE_4B;
  assign read_burst = BURST_INCR;
  assign busy       = (state != ST_IDLE);

  assign accept  = frame_ready && (state == ST_IDLE);
  assign dims_ok = (frame_width != '0) && (frame_height != '0);

  // Stop accepting once the whole burst has been taken, even if memory overruns.
  assign read_ready = (state == ST_STREAM) && !fifo_full && (beats_received < read_len);
  assign push       = read_valid && read_ready;

  assign m_axis_tvalid = (fifo_level != '0);
  assign pop           = m_axis_tready && !fifo_empty;

  assign col_last     = (col == dim_last(width_q));
  assign line_last    = (line == dim_last(height_q));
  assign m_axis_tlast = m_axis_tvalid && col_last;
  assign m_axis_tuser = m_axis_tvalid && (col == '0) && (line == '0);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (read_data),
    .pop       (pop),
    .pop_data  (m_axis_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  // Frame sequencing, request registers and pixel position tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      start_read     <= 1'b0;
      read_addr      <= '0;
      read_len       <= '0;
      width_q        <= '0;
      height_q       <= '0;
      col            <= '0;
      line           <= '0;
      beats_received <= '0;
      frame_done     <= 1'b0;
    end else begin
      start_read <= 1'b0;
      frame_done <= 1'b0;

      if (push) begin
        beats_received <= LEN_W'(beats_received + LEN_W'(1));
      end

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dims_ok) begin
              read_addr      <= base_addr_in;
              read_len       <= pixels_per_frame;
              width_q        <= frame_width;
              height_q       <= frame_height;
              col            <= '0;
              line           <= '0;
              beats_received <= '0;
              start_read     <= 1'b1;
              state          <= ST_REQ;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_REQ: begin
          state <= ST_STREAM;
        end

        ST_STREAM: begin
          if (pop) begin
            if (col_last) begin
              col  <= '0;
              line <= DIM_W'(line + DIM_W'(1));
            end else begin
              col <= DIM_W'(col + DIM_W'(1));
            end
            if (col_last && line_last) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // An empty frame arrives here without the pulse; emit it before leaving.
          col  <= '0;
          line <= '0;
          if (!frame_done) begin
            frame_done <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEMORY_READER_UNDERRUN_CNT_EN
  // Cycles where the sink would take a pixel but none is buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (accept && dims_ok) begin
      underrun_count <= '0;
    end else if ((state == ST_STREAM) && m_axis_tready && fifo_empty &&
                 (underrun_count != {UNDERRUN_W{1'b1}})) begin
      underrun_count <= UNDERRUN_W'(underrun_count + UNDERRUN_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_memory_reader.sv
// Scoreboard bench for memory_reader: memory model feeds expected pixels, a monitor checks the stream.
module tb_memory_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pixels_per_frame;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic        frame_ready;
  logic [31:0] base_addr_in;
  logic        start_read;
  logic [31:0] read_addr;
  logic [31:0] read_len;
  logic [2:0]  read_size;
  logic [1:0]  read_burst;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic        busy;
`ifdef MEMORY_READER_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  memory_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pixels_per_frame (pixels_per_frame),
    .frame_width      (frame_width),
    .frame_height     (frame_height),
    .frame_ready      (frame_ready),
    .base_addr_in     (base_addr_in),
    .start_read       (start_read),
    .read_addr        (read_addr),
    .read_len         (read_len),
    .read_size        (read_size),
    .read_burst       (read_burst),
    .read_data        (read_data),
    .read_valid       (read_valid),
    .read_ready       (read_ready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .frame_done       (frame_done),
    .busy             (busy)
`ifdef MEMORY_READER_UNDERRUN_CNT_EN
    ,
    .underrun_count   (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pix_t sb[$];
  int   exp_w, exp_len, mem_beats;
  logic [31:0] exp_addr, mem_seed;
  int   fr_cyc, sr_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, pix_seen = 0;
  int   sink_mode = 0;   // 0: always ready, 1: toggle, 2: held low
  logic mem_busy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink readiness pattern.
  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Memory model: answers each start_read with mem_beats consecutive words.
  always begin
    @(negedge clk);
    if (rst_n && start_read) begin
      int  waited;
      int  limit;
      logic acc;
      logic aborted;
      mem_busy = 1'b1;
      aborted  = 1'b0;
      for (int i = 0; i < mem_beats && !aborted; i++) begin
        @(posedge clk); #1;
        read_valid = 1'b1;
        read_data  = mem_seed + 32'(i);
        waited = 0;
        acc    = 1'b0;
        limit  = (i < exp_len) ? 400 : 4;
        while (!acc && !aborted && waited < limit) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
          end else begin
            if (i >= exp_len) chk("extra_beat_refused", 64'(read_ready), 64'd0);
            if (read_ready) begin
              acc = 1'b1;
              if (i < exp_len)
                sb.push_back('{data: mem_seed + 32'(i),
                               last: ((i % exp_w) == exp_w - 1),
                               user: (i == 0)});
            end else begin
              waited++;
              if (waited < limit) begin
                @(posedge clk); #1;
              end else if (i < exp_len) begin
                chk("beat_accept_timeout", 64'd0, 64'd1);
                aborted = 1'b1;
              end
            end
          end
        end
      end
      if (!aborted) begin
        @(posedge clk); #1;
      end
      read_valid = 1'b0;
      mem_busy   = 1'b0;
    end
  end

  // Monitor: request checks, stream scoreboard, AXI-S stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last, prev_user;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
            {1'b1, prev_data, prev_last, prev_user});
      end
      if (start_read) begin
        sr_cnt++;
        chk("start_addr", 64'(read_addr), 64'(exp_addr));
        chk("start_len", 64'(read_len), 64'(exp_len));
        chk("start_latency", 64'(cyc), 64'(fr_cyc + 1));
        chk("size_burst", {59'd0, read_size, read_burst}, {59'd0, 3'd2, 2'b01});
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        pix_t e;
        if (sb.size() == 0) begin
          chk("unexpected_pixel", 64'(m_axis_tdata), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("pixel", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, {e.data, e.last, e.user});
        end
        pix_seen++;
        if (pix_seen == exp_len) last_hs_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser;
    end
  end

  task automatic setup_frame(input int w, input int h, input logic [31:0] base,
                             input int beats, input logic [31:0] seed);
    frame_width      = 16'(w);
    frame_height     = 16'(h);
    pixels_per_frame = 32'(w * h);
    base_addr_in     = base;
    exp_w     = w;
    exp_len   = w * h;
    exp_addr  = base;
    mem_beats = beats;
    mem_seed  = seed;
    pix_seen  = 0;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1;
    frame_ready = 1'b1;
    fr_cyc = cyc;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk("frame_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_mem_idle();
    int n = 0;
    while (mem_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mem_busy) chk("memory_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_start"}, 64'(start_read), 64'd0);
    chk({tag, "_req"}, {read_addr, read_len}, 64'd0);
    chk({tag, "_size_burst"}, {59'd0, read_size, read_burst}, {59'd0, 3'd2, 2'b01});
    chk({tag, "_stream"}, {read_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
        64'd0);
    chk({tag, "_done_busy"}, {62'd0, frame_done, busy}, 64'd0);
  endtask

  task automatic run_normal(input int w, input int h, input logic [31:0] base,
                            input int beats, input logic [31:0] seed);
    int d0, s0;
    setup_frame(w, h, base, beats, seed);
    d0 = done_cnt;
    s0 = sr_cnt;
    pulse_frame();
    wait_done(d0, 300);
    chk("done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
    wait_mem_idle();
    repeat (2) @(negedge clk);
    chk("start_count", 64'(sr_cnt - s0), 64'd1);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("pixel_count", 64'(pix_seen), 64'(w * h));
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int d0, s0, n;
    rst_n = 1'b0;
    frame_ready = 1'b0;
    read_valid = 1'b0;
    read_data = '0;
    m_axis_tready = 1'b1;
    setup_frame(4, 2, 32'h0, 0, 32'h0);
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 4x2 frame, back-to-back memory, sink always ready.
    sink_mode = 0;
    run_normal(4, 2, 32'h100, 8, 32'hA000_0000);

    // Memory offers 10 beats for an 8-beat burst.
    run_normal(4, 2, 32'h180, 10, 32'hB000_0000);

    // 4x4 frame: sink stalled until FIFO is full, then toggles; stray frame_ready mid-stream.
    setup_frame(4, 4, 32'h200, 16, 32'hC000_0000);
    d0 = done_cnt;
    s0 = sr_cnt;
    sink_mode = 2;
    pulse_frame();
    repeat (20) @(negedge clk);
    chk("full_read_ready", {62'd0, read_ready, m_axis_tvalid}, {62'd0, 1'b0, 1'b1});
    chk("full_accepted", 64'(sb.size()), 64'd8);
    @(posedge clk); #1;
    base_addr_in = 32'h999;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    sink_mode = 1;
    wait_done(d0, 400);
    chk("toggle_done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
    wait_mem_idle();
    repeat (2) @(negedge clk);
    chk("toggle_start_count", 64'(sr_cnt - s0), 64'd1);
    chk("toggle_done_count", 64'(done_cnt - d0), 64'd1);
    chk("toggle_pixel_count", 64'(pix_seen), 64'd16);
    chk("toggle_sb_drained", 64'(sb.size()), 64'd0);
    sink_mode = 0;

    // Zero width: frame_done two cycles after the request, no burst.
    setup_frame(0, 2, 32'h280, 0, 32'h0);
    d0 = done_cnt;
    s0 = sr_cnt;
    pulse_frame();
    @(negedge clk);
    chk("zero_busy", 64'(busy), 64'd1);
    wait_done(d0, 20);
    chk("zero_done_latency", 64'(done_cyc), 64'(fr_cyc + 2));
    repeat (3) @(negedge clk);
    chk("zero_no_start", 64'(sr_cnt - s0), 64'd0);
    chk("zero_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset after three pixels, then a clean frame.
    setup_frame(4, 2, 32'h300, 8, 32'hD000_0000);
    d0 = done_cnt;
    pulse_frame();
    n = 0;
    while (pix_seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_pixels", 64'(pix_seen), 64'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_reset_outputs("midreset");
    wait_mem_idle();
    sb.delete();
    repeat (3) @(negedge clk);
    chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_normal(4, 2, 32'h400, 8, 32'hE000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
